// File: rtl/sa_cache_tag_pkg.sv
// -----------------------------------------------------------------------------
// icache_def
// Shared types for the set-associative cache tag store.
//   sa_tag_entry_t   : one stored tag entry {valid, dirty, tag}
//   sa_flush_state_t : state encoding of the flush sequencer
// SA_TAG_W is the default tag width the entry struct is built with.
// -----------------------------------------------------------------------------
package icache_def;

  localparam int SA_TAG_W = 18;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [SA_TAG_W-1:0] tag;
  } sa_tag_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DONE
  } sa_flush_state_t;

endpackage

// File: rtl/sa_tag_way_bank.sv
// -----------------------------------------------------------------------------
// sa_tag_way_bank
// Storage for one way of the tag store: SETS entries of {valid, dirty, tag}.
//   clk, rst_n                    : clock, synchronous active-low reset
//   rd_index -> rd_valid/dirty/tag : combinational read of one set
//   wr_en, wr_index, wr_tag, wr_dirty : write one entry, marking it valid
//   clr_en, clr_index             : clear valid and dirty of one set, tag kept
// -----------------------------------------------------------------------------
module sa_tag_way_bank
  import icache_def::*;
#(
  parameter  int SETS  = 8,
  parameter  int TAG_W = 18,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_dirty,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_index
);

  logic             valid_q [SETS];
  logic             dirty_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS];

  // The clear is listed after the write so it wins if both ever hit one set;
  // the top never issues both because writes are blocked while flushing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 1'b0;
        dirty_q[s] <= 1'b0;
        tag_q[s]   <= '0;
      end
    end else begin
      if (wr_en) begin
        valid_q[wr_index] <= 1'b1;
        dirty_q[wr_index] <= wr_dirty;
        tag_q[wr_index]   <= wr_tag;
      end
      if (clr_en) begin
        valid_q[clr_index] <= 1'b0;
        dirty_q[clr_index] <= 1'b0;
      end
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];

endmodule

// File: rtl/sa_cache_tag.sv
// -----------------------------------------------------------------------------
// sa_cache_tag
// N-way set-associative tag store with registered lookup, victim selection,
// per-set round-robin replacement pointer and a one-set-per-cycle flush.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_valid/ready/index/tag : lookup request (ready low while flushing)
//   lookup_valid/hit/way  : registered lookup result, one cycle after accept
//   lookup_victim_*       : replacement way and its stored state
//   wr_en/index/way/tag/dirty : entry fill/update, ignored while flushing
//   flush_start/busy/done : invalidate-all sequencer control and status
// -----------------------------------------------------------------------------
module sa_cache_tag
  import icache_def::*;
#(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 8,
  parameter  int TAG_W = 18,
  localparam int IDX_W = $clog2(SETS),
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  output logic             lookup_valid,
  output logic             lookup_hit,
  output logic [WAY_W-1:0] lookup_way,
  output logic [WAY_W-1:0] lookup_victim_way,
  output logic             lookup_victim_valid,
  output logic             lookup_victim_dirty,
  output logic [TAG_W-1:0] lookup_victim_tag,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [WAY_W-1:0] wr_way,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_dirty,
  input  logic             flush_start,
  output logic             flush_busy,
  output logic             flush_done
);

  sa_flush_state_t  state, state_next;
  logic [IDX_W-1:0] counter, counter_next;
  logic             clr_en;
  logic             wr_accept;
  logic             req_accept;

  logic [WAY_W-1:0] rr_ptr [SETS];

  logic             way_valid [WAYS];
  logic             way_dirty [WAYS];
  logic [TAG_W-1:0] way_tag   [WAYS];

  logic             hit_c;
  logic [WAY_W-1:0] hit_way_c;
  logic [WAY_W-1:0] victim_way_c;
  logic             victim_valid_c;
  logic             victim_dirty_c;
  logic [TAG_W-1:0] victim_tag_c;

  assign req_ready  = (state == IDLE);
  assign flush_busy = (state != IDLE);
  assign flush_done = (state == DONE);
  assign req_accept = req_valid && req_ready;
  assign wr_accept  = wr_en && (state == IDLE);

  // One bank per way; all banks are read at req_index so the lookup sees the
  // array contents from before any write landing on the same edge.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    sa_tag_way_bank #(
      .SETS  (SETS),
      .TAG_W (TAG_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_index  (req_index),
      .rd_valid  (way_valid[w]),
      .rd_dirty  (way_dirty[w]),
      .rd_tag    (way_tag[w]),
      .wr_en     (wr_accept && (wr_way == WAY_W'(w))),
      .wr_index  (wr_index),
      .wr_tag    (wr_tag),
      .wr_dirty  (wr_dirty),
      .clr_en    (clr_en),
      .clr_index (counter)
    );
  end

  // Walking the ways from high to low lets the lowest matching way and the
  // lowest invalid way win; the round-robin pointer is only the fallback.
  always_comb begin
    hit_c        = 1'b0;
    hit_way_c    = '0;
    victim_way_c = rr_ptr[req_index];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_valid[w] && (way_tag[w] == req_tag)) begin
        hit_c     = 1'b1;
        hit_way_c = WAY_W'(w);
      end
      if (!way_valid[w]) begin
        victim_way_c = WAY_W'(w);
      end
    end
  end

  // Report the stored state of whichever way was chosen as victim.
  always_comb begin
    victim_valid_c = 1'b0;
    victim_dirty_c = 1'b0;
    victim_tag_c   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (victim_way_c == WAY_W'(w)) begin
        victim_valid_c = way_valid[w];
        victim_dirty_c = way_dirty[w];
        victim_tag_c   = way_tag[w];
      end
    end
  end

  // Result registers hold a lookup for exactly one cycle and return to zero
  // whenever no request was accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lookup_valid        <= 1'b0;
      lookup_hit          <= 1'b0;
      lookup_way          <= '0;
      lookup_victim_way   <= '0;
      lookup_victim_valid <= 1'b0;
      lookup_victim_dirty <= 1'b0;
      lookup_victim_tag   <= '0;
    end else begin
      lookup_valid        <= req_accept;
      lookup_hit          <= req_accept ? hit_c          : 1'b0;
      lookup_way          <= req_accept ? hit_way_c      : '0;
      lookup_victim_way   <= req_accept ? victim_way_c   : '0;
      lookup_victim_valid <= req_accept ? victim_valid_c : 1'b0;
      lookup_victim_dirty <= req_accept ? victim_dirty_c : 1'b0;
      lookup_victim_tag   <= req_accept ? victim_tag_c   : '0;
    end
  end

  // A write into the way the set's pointer names moves the pointer on, so
  // the next replacement in that set goes to the following way.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        rr_ptr[s] <= '0;
      end
    end else if (wr_accept && (wr_way == rr_ptr[wr_index])) begin
      if (rr_ptr[wr_index] == WAY_W'(WAYS - 1)) begin
        rr_ptr[wr_index] <= '0;
      end else begin
        rr_ptr[wr_index] <= rr_ptr[wr_index] + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // Flush walks every set once, then spends one cycle in DONE to pulse
  // flush_done before reopening the request port.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    clr_en       = 1'b0;
    case (state)
      IDLE: begin
        if (flush_start) begin
          state_next   = FLUSH;
          counter_next = '0;
        end
      end
      FLUSH: begin
        clr_en = 1'b1;
        if (counter == IDX_W'(SETS - 1)) begin
          state_next = DONE;
        end else begin
          counter_next = counter + IDX_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sa_cache_tag.sv
// -----------------------------------------------------------------------------
// tb_sa_cache_tag
// Directed bench for sa_cache_tag: a default 2-way/8-set instance and a
// 4-way/16-set/20-bit-tag instance sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_sa_cache_tag;

  logic clk;
  logic rst_n;

  // 2-way, 8-set, 18-bit tag instance
  logic        req_valid, req_ready;
  logic [2:0]  req_index;
  logic [17:0] req_tag;
  logic        lookup_valid, lookup_hit;
  logic        lookup_way, lookup_victim_way;
  logic        lookup_victim_valid, lookup_victim_dirty;
  logic [17:0] lookup_victim_tag;
  logic        wr_en;
  logic [2:0]  wr_index;
  logic        wr_way;
  logic [17:0] wr_tag;
  logic        wr_dirty;
  logic        flush_start, flush_busy, flush_done;

  // 4-way, 16-set, 20-bit tag instance
  logic        req_valid4, req_ready4;
  logic [3:0]  req_index4;
  logic [19:0] req_tag4;
  logic        lookup_valid4, lookup_hit4;
  logic [1:0]  lookup_way4, lookup_victim_way4;
  logic        lookup_victim_valid4, lookup_victim_dirty4;
  logic [19:0] lookup_victim_tag4;
  logic        wr_en4;
  logic [3:0]  wr_index4;
  logic [1:0]  wr_way4;
  logic [19:0] wr_tag4;
  logic        wr_dirty4;
  logic        flush_start4, flush_busy4, flush_done4;

  int checks = 0;
  int errors = 0;

  sa_cache_tag dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_index           (req_index),
    .req_tag             (req_tag),
    .lookup_valid        (lookup_valid),
    .lookup_hit          (lookup_hit),
    .lookup_way          (lookup_way),
    .lookup_victim_way   (lookup_victim_way),
    .lookup_victim_valid (lookup_victim_valid),
    .lookup_victim_dirty (lookup_victim_dirty),
    .lookup_victim_tag   (lookup_victim_tag),
    .wr_en               (wr_en),
    .wr_index            (wr_index),
    .wr_way              (wr_way),
    .wr_tag              (wr_tag),
    .wr_dirty            (wr_dirty),
    .flush_start         (flush_start),
    .flush_busy          (flush_busy),
    .flush_done          (flush_done)
  );

  sa_cache_tag #(.WAYS(4), .SETS(16), .TAG_W(20)) dut4 (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid           (req_valid4),
    .req_ready           (req_ready4),
    .req_index           (req_index4),
    .req_tag             (req_tag4),
    .lookup_valid        (lookup_valid4),
    .lookup_hit          (lookup_hit4),
    .lookup_way          (lookup_way4),
    .lookup_victim_way   (lookup_victim_way4),
    .lookup_victim_valid (lookup_victim_valid4),
    .lookup_victim_dirty (lookup_victim_dirty4),
    .lookup_victim_tag   (lookup_victim_tag4),
    .wr_en               (wr_en4),
    .wr_index            (wr_index4),
    .wr_way              (wr_way4),
    .wr_tag              (wr_tag4),
    .wr_dirty            (wr_dirty4),
    .flush_start         (flush_start4),
    .flush_busy          (flush_busy4),
    .flush_done          (flush_done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; everything is driven and sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, observed, expected);
    end
  endtask

  // One cycle of optional lookup, write and flush start on the 2-way instance.
  task automatic applyStimulus(input logic lk, input logic [2:0] idx, input logic [17:0] tag,
                               input logic wr, input logic [2:0] widx, input logic wway,
                               input logic [17:0] wtag, input logic wdirty, input logic fs);
    req_valid   = lk;
    req_index   = idx;
    req_tag     = tag;
    wr_en       = wr;
    wr_index    = widx;
    wr_way      = wway;
    wr_tag      = wtag;
    wr_dirty    = wdirty;
    flush_start = fs;
    tick();
    req_valid   = 1'b0;
    wr_en       = 1'b0;
    flush_start = 1'b0;
  endtask

  task automatic applyStimulus4(input logic lk, input logic [3:0] idx, input logic [19:0] tag,
                                input logic wr, input logic [3:0] widx, input logic [1:0] wway,
                                input logic [19:0] wtag, input logic wdirty);
    req_valid4 = lk;
    req_index4 = idx;
    req_tag4   = tag;
    wr_en4     = wr;
    wr_index4  = widx;
    wr_way4    = wway;
    wr_tag4    = wtag;
    wr_dirty4  = wdirty;
    tick();
    req_valid4 = 1'b0;
    wr_en4     = 1'b0;
  endtask

  task automatic checkLookup(input string name, input logic hit, input logic way,
                             input logic vway, input logic vvalid, input logic vdirty,
                             input logic [17:0] vtag);
    checkOutput({name, ".valid"}, 32'(lookup_valid), 32'd1);
    checkOutput({name, ".hit"}, 32'(lookup_hit), 32'(hit));
    if (hit) checkOutput({name, ".way"}, 32'(lookup_way), 32'(way));
    checkOutput({name, ".vway"}, 32'(lookup_victim_way), 32'(vway));
    checkOutput({name, ".vvalid"}, 32'(lookup_victim_valid), 32'(vvalid));
    checkOutput({name, ".vdirty"}, 32'(lookup_victim_dirty), 32'(vdirty));
    checkOutput({name, ".vtag"}, 32'(lookup_victim_tag), 32'(vtag));
  endtask

  task automatic checkLookup4(input string name, input logic hit, input logic [1:0] way,
                              input logic [1:0] vway, input logic vvalid, input logic vdirty,
                              input logic [19:0] vtag);
    checkOutput({name, ".valid"}, 32'(lookup_valid4), 32'd1);
    checkOutput({name, ".hit"}, 32'(lookup_hit4), 32'(hit));
    if (hit) checkOutput({name, ".way"}, 32'(lookup_way4), 32'(way));
    checkOutput({name, ".vway"}, 32'(lookup_victim_way4), 32'(vway));
    checkOutput({name, ".vvalid"}, 32'(lookup_victim_valid4), 32'(vvalid));
    checkOutput({name, ".vdirty"}, 32'(lookup_victim_dirty4), 32'(vdirty));
    checkOutput({name, ".vtag"}, 32'(lookup_victim_tag4), 32'(vtag));
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_index = '0; req_tag = '0;
    wr_en = 1'b0; wr_index = '0; wr_way = 1'b0; wr_tag = '0; wr_dirty = 1'b0;
    flush_start = 1'b0;
    req_valid4 = 1'b0; req_index4 = '0; req_tag4 = '0;
    wr_en4 = 1'b0; wr_index4 = '0; wr_way4 = '0; wr_tag4 = '0; wr_dirty4 = 1'b0;
    flush_start4 = 1'b0;

    tick();
    tick();
    rst_n = 1'b1;
    $display("[TB] reset values");
    checkOutput("rst.lookup_valid", 32'(lookup_valid), 32'd0);
    checkOutput("rst.flush_busy", 32'(flush_busy), 32'd0);
    checkOutput("rst.flush_done", 32'(flush_done), 32'd0);
    checkOutput("rst.req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst.req_ready4", 32'(req_ready4), 32'd1);

    $display("[TB] lookup on empty array");
    applyStimulus(1, 3'd3, 18'h155, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("empty", 0, 0, 0, 0, 0, 18'h0);
    tick();
    checkOutput("empty.held_one_cycle", 32'(lookup_valid), 32'd0);

    $display("[TB] fills and round-robin victim");
    applyStimulus(0, 3'd0, 18'h0, 1, 3'd3, 0, 18'h155, 0, 0);
    applyStimulus(1, 3'd3, 18'h0FF, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("one_fill", 0, 0, 1, 0, 0, 18'h0);
    applyStimulus(0, 3'd0, 18'h0, 1, 3'd3, 1, 18'h2AA, 1, 0);
    applyStimulus(1, 3'd3, 18'h2AA, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("hit_way1", 1, 1, 0, 1, 0, 18'h155);
    applyStimulus(1, 3'd3, 18'h0FF, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("miss_full", 0, 0, 0, 1, 0, 18'h155);
    applyStimulus(0, 3'd0, 18'h0, 1, 3'd3, 0, 18'h0FF, 0, 0);
    applyStimulus(1, 3'd3, 18'h333, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("victim_way1", 0, 0, 1, 1, 1, 18'h2AA);

    $display("[TB] read-before-write and back-to-back lookups");
    req_valid = 1'b1; req_index = 3'd5; req_tag = 18'h011;
    wr_en = 1'b1; wr_index = 3'd5; wr_way = 1'b0; wr_tag = 18'h011; wr_dirty = 1'b0;
    tick();
    wr_en = 1'b0;
    checkLookup("rbw_first", 0, 0, 0, 0, 0, 18'h0);
    tick();
    req_valid = 1'b0;
    checkLookup("rbw_second", 1, 0, 1, 0, 0, 18'h0);

    $display("[TB] fill all sets then flush");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 3'd0, 18'h0, 1, 3'(i), 0, 18'h100 + 18'(i), 1, 0);
    end
    applyStimulus(1, 3'd2, 18'h102, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("pre_flush", 1, 0, 1, 0, 0, 18'h0);
    applyStimulus(0, 3'd0, 18'h0, 1, 3'd0, 1, 18'h055, 0, 1);
    req_valid = 1'b1; req_index = 3'd4; req_tag = 18'h3FF;
    for (int c = 0; c < 9; c++) begin
      checkOutput($sformatf("flush.busy[%0d]", c), 32'(flush_busy), 32'd1);
      checkOutput($sformatf("flush.ready[%0d]", c), 32'(req_ready), 32'd0);
      checkOutput($sformatf("flush.done[%0d]", c), 32'(flush_done), 32'(c == 8));
      checkOutput($sformatf("flush.lookup_valid[%0d]", c), 32'(lookup_valid), 32'd0);
      flush_start = (c == 3);
      if (c == 6) begin
        wr_en = 1'b1; wr_index = 3'd4; wr_way = 1'b1; wr_tag = 18'h3FF; wr_dirty = 1'b1;
      end
      if (c == 7) wr_en = 1'b0;
      if (c == 8) req_valid = 1'b0;
      tick();
    end
    checkOutput("flush.end_busy", 32'(flush_busy), 32'd0);
    checkOutput("flush.end_done", 32'(flush_done), 32'd0);
    checkOutput("flush.end_ready", 32'(req_ready), 32'd1);
    applyStimulus(1, 3'd2, 18'h102, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("post_flush_s2", 0, 0, 0, 0, 0, 18'h102);
    applyStimulus(1, 3'd4, 18'h3FF, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("post_flush_wr_ignored", 0, 0, 0, 0, 0, 18'h104);
    applyStimulus(1, 3'd0, 18'h055, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("post_flush_same_cycle_wr", 0, 0, 0, 0, 0, 18'h100);

    $display("[TB] reset during flush");
    applyStimulus(0, 3'd0, 18'h0, 1, 3'd6, 0, 18'h066, 0, 0);
    applyStimulus(0, 3'd0, 18'h0, 0, 3'd0, 0, 18'h0, 0, 1);
    tick();
    tick();
    tick();
    checkOutput("midrst.busy_before", 32'(flush_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst.busy", 32'(flush_busy), 32'd0);
    checkOutput("midrst.done", 32'(flush_done), 32'd0);
    checkOutput("midrst.ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst.done_after", 32'(flush_done), 32'd0);
    applyStimulus(1, 3'd6, 18'h066, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("midrst_s6", 0, 0, 0, 0, 0, 18'h0);
    applyStimulus(1, 3'd7, 18'h107, 0, 3'd0, 0, 18'h0, 0, 0);
    checkLookup("midrst_s7", 0, 0, 0, 0, 0, 18'h0);

    $display("[TB] 4-way instance replacement order");
    for (int k = 0; k < 4; k++) begin
      applyStimulus4(1, 4'd9, 20'h10000 + 20'(k), 0, 4'd0, 2'd0, 20'h0, 0);
      checkLookup4($sformatf("w4_fill%0d", k), 0, 2'd0, 2'(k), 0, 0, 20'h0);
      applyStimulus4(0, 4'd0, 20'h0, 1, 4'd9, 2'(k), 20'h10000 + 20'(k), 1'(k));
    end
    applyStimulus4(1, 4'd9, 20'h10002, 0, 4'd0, 2'd0, 20'h0, 0);
    checkLookup4("w4_hit2", 1, 2'd2, 2'd0, 1, 0, 20'h10000);
    applyStimulus4(1, 4'd9, 20'hABCDE, 0, 4'd0, 2'd0, 20'h0, 0);
    checkLookup4("w4_fill4", 0, 2'd0, 2'd0, 1, 0, 20'h10000);
    applyStimulus4(0, 4'd0, 20'h0, 1, 4'd9, 2'd0, 20'hABCDE, 1);
    applyStimulus4(1, 4'd9, 20'h12345, 0, 4'd0, 2'd0, 20'h0, 0);
    checkLookup4("w4_fill5", 0, 2'd0, 2'd1, 1, 1, 20'h10001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
